serial_tx_arbiter: RTL

//  Shares one SerialTX UART transmitter between NUM_CH byte-stream requesters.

---
 rtl/serial_tx_arbiter_pkg.sv | 23 ++
 rtl/serial_tx_arbiter_if.sv | 25 ++
 rtl/serial_tx_arbiter_rr.sv | 31 +++
 rtl/serial_tx_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/serial_tx_arbiter_pkg.sv
// rtl/serial_tx_arbiter_pkg.sv - shared FSM encoding, constants and helpers for the SerialTX arbiter
package serial_tx_arbiter_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_HDR     = 3'd1;
    localparam state_t ST_DATA    = 3'd2;
    localparam state_t ST_WAIT_HI = 3'd3;
    localparam state_t ST_WAIT_LO = 3'd4;

    localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_tx_arbiter_if.sv
// rtl/serial_tx_arbiter_if.sv - requester byte streams plus the SerialTX start/data/busy port
interface serial_tx_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
);
    logic [NUM_CH-1:0]   req_valid;
    logic [8*NUM_CH-1:0] req_data;
    logic [NUM_CH-1:0]   req_last;
    logic [NUM_CH-1:0]   req_ready;
    logic                tx_start;
    logic [7:0]          tx_data;
    logic                tx_busy;
    logic [CH_W-1:0]     grant_ch;
    logic                grant_active;

    modport master (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data, grant_ch, grant_active
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data, grant_ch, grant_active
    );
endinterface

// File: rtl/serial_tx_arbiter_rr.sv
// rtl/serial_tx_arbiter_rr.sv - combinational round-robin pick of the first request at/after a pointer
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   idx_o,
    output logic              any_o
);
    always_comb begin : pick
        int              ci;
        logic [CH_W-1:0] c;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        ci    = 0;
        c     = '0;
        // Wrap modulo NUM_CH, which need not be a power of two.
        for (int k = 0; k < NUM_CH; k++) begin
            ci = (int'(ptr_i) + k) % NUM_CH;
            c  = CH_W'(ci);
            if (!any_o && req_i[c]) begin
                any_o    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = c;
            end
        end
    end
endmodule

// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - shares one SerialTX between NUM_CH byte streams, round-robin per message
module serial_tx_arbiter
    import serial_tx_arbiter_pkg::*;
#(
    parameter int         NUM_CH    = 4,
    parameter int         CH_W      = 2,
    parameter bit         HDR_EN    = 1'b1,
    parameter logic [7:0] HDR_BASE  = HDR_BASE_DEFAULT,
    parameter int         MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_tx_arbiter_if.master bus
);
    localparam int BURST_W = (MAX_BURST > 0) ? clog2(MAX_BURST + 1) : 1;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [CH_W-1:0]     grant_ch_q, grant_ch_d;
    logic [NUM_CH-1:0]   grant_oh_q, grant_oh_d;
    logic                grant_active_q, grant_active_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic                last_q, last_d;
    logic                hdr_q, hdr_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [NUM_CH-1:0]   req_ready;

    logic [NUM_CH-1:0]   rr_gnt;
    logic [CH_W-1:0]     rr_idx;
    logic                rr_any;
    logic                gnt_valid;
    logic                gnt_last;
    logic [7:0]          gnt_byte;
    logic                burst_hit;
    logic [CH_W-1:0]     ptr_next;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx),
        .any_o (rr_any)
    );

    assign gnt_valid = |(bus.req_valid & grant_oh_q);
    assign gnt_last  = |(bus.req_last & grant_oh_q);
    assign gnt_byte  = bus.req_data[{grant_ch_q, 3'b000} +: 8];
    assign burst_hit = (MAX_BURST != 0) && (burst_q == BURST_W'(MAX_BURST));
    assign ptr_next  = (grant_ch_q == CH_W'(NUM_CH - 1)) ? '0 : grant_ch_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        grant_ch_d     = grant_ch_q;
        grant_oh_d     = grant_oh_q;
        grant_active_d = grant_active_q;
        burst_d        = burst_q;
        last_d         = last_q;
        hdr_d          = hdr_q;
        tx_start_d     = 1'b0;
        tx_data_d      = tx_data_q;
        req_ready      = '0;
        case (state_q)
            ST_IDLE: begin
                // The busy gate also covers a frame left running across our own reset.
                if (rr_any && !bus.tx_busy) begin
                    grant_ch_d     = rr_idx;
                    grant_oh_d     = rr_gnt;
                    grant_active_d = 1'b1;
                    state_d        = HDR_EN ? ST_HDR : ST_DATA;
                end
            end
            ST_HDR: begin
                tx_data_d  = HDR_BASE + 8'(grant_ch_q);
                tx_start_d = 1'b1;
                hdr_d      = 1'b1;
                state_d    = ST_WAIT_HI;
            end
            ST_DATA: begin
                if (gnt_valid) begin
                    req_ready  = grant_oh_q;
                    tx_data_d  = gnt_byte;
                    tx_start_d = 1'b1;
                    last_d     = gnt_last;
                    hdr_d      = 1'b0;
                    burst_d    = burst_q + 1'b1;
                    state_d    = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    if (!hdr_q && (last_q || burst_hit)) begin
                        grant_active_d = 1'b0;
                        ptr_d          = ptr_next;
                        burst_d        = '0;
                        last_d         = 1'b0;
                        state_d        = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            grant_ch_q     <= '0;
            grant_oh_q     <= '0;
            grant_active_q <= 1'b0;
            burst_q        <= '0;
            last_q         <= 1'b0;
            hdr_q          <= 1'b0;
            tx_start_q     <= 1'b0;
            tx_data_q      <= 8'h00;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            grant_ch_q     <= grant_ch_d;
            grant_oh_q     <= grant_oh_d;
            grant_active_q <= grant_active_d;
            burst_q        <= burst_d;
            last_q         <= last_d;
            hdr_q          <= hdr_d;
            tx_start_q     <= tx_start_d;
            tx_data_q      <= tx_data_d;
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.tx_start     = tx_start_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.grant_ch     = grant_ch_q;
    assign bus.grant_active = grant_active_q;

endmodule
